// File: rtl/upc_encoder.sv
// Letter-at-a-time product name encoder: narrows a candidate mask over the
// product table as letters arrive and pulses the matched 3-bit UPC code.
module upc_encoder #(
  parameter int LETTER_W = 5,
  parameter int MAX_LEN  = 6,
  parameter int BLANK    = 26
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [LETTER_W-1:0] letter_in,
  input  logic                letter_valid,
  output logic                letter_ready,
  output logic [2:0]          upc_out,
  output logic                upc_valid,
  output logic                upc_error,
  output logic [2:0]          pos
);

  localparam int N = 6;
  localparam logic [LETTER_W-1:0] B = LETTER_W'(BLANK);
  localparam logic [2:0] LAST_POS = 3'(MAX_LEN - 1);

  // Each word packs its first letter in the least significant field.
  localparam logic [MAX_LEN*LETTER_W-1:0] WORDS [N] = '{
    {B,     5'd18, 5'd6,  5'd20, 5'd17, 5'd3 },  // DRUGS
    {B,     5'd24, 5'd3,  5'd13, 5'd0,  5'd2 },  // CANDY
    {B,     B,     5'd15, 5'd0,  5'd14, 5'd18},  // SOAP
    {5'd4,  5'd13, 5'd14, 5'd7,  5'd15, 5'd8 },  // IPHONE
    {B,     5'd3,  5'd8,  5'd14, 5'd17, 5'd3 },  // DROID
    {B,     B,     5'd18, 5'd3,  5'd4,  5'd11}   // LEDS
  };
  localparam logic [2:0] CODES [N] = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b101, 3'b110};

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t               state;
  logic [N-1:0]         mask;
  logic [N-1:0]         match;
  logic [N-1:0]         mask_next;
  logic [2:0]           pos_idx;
  logic [2:0]           hit_code;
  logic                 hit;
  logic                 accept;
  logic                 illegal;
  logic                 is_blank;
  logic                 term;
  logic [LETTER_W-1:0]  chars [N][MAX_LEN];

  assign pos_idx = (pos <= LAST_POS) ? pos : 3'd0;

  for (genvar gi = 0; gi < N; gi++) begin : g_entry
    for (genvar pj = 0; pj < MAX_LEN; pj++) begin : g_char
      assign chars[gi][pj] = WORDS[gi][pj*LETTER_W +: LETTER_W];
    end
    assign match[gi] = (pos <= LAST_POS) && (chars[gi][pos_idx] == letter_in);
  end

  assign accept    = letter_valid & letter_ready;
  assign illegal   = letter_in > B;
  assign is_blank  = letter_in == B;
  assign mask_next = mask & match;
  assign hit       = (mask_next != '0) && ((mask_next & (mask_next - N'(1))) == '0);

  // A word ends on a blank after at least one letter, or on its last letter.
  assign term = accept && !illegal &&
                ((is_blank && state == COLLECT) || (!is_blank && pos == LAST_POS));

  always_comb begin
    hit_code = '0;
    for (int i = 0; i < N; i++) begin
      if (mask_next[i]) hit_code = hit_code | CODES[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pos          <= '0;
      mask         <= '1;
      upc_out      <= 3'b000;
      upc_valid    <= 1'b0;
      upc_error    <= 1'b0;
      letter_ready <= 1'b1;
    end else begin
      upc_valid <= 1'b0;
      upc_error <= 1'b0;
      case (state)
        IDLE, COLLECT: begin
          if (accept && illegal) begin
            upc_error    <= 1'b1;
            state        <= DONE;
            letter_ready <= 1'b0;
          end else begin
            if (accept && !is_blank) begin
              mask  <= mask_next;
              pos   <= pos + 3'd1;
              state <= COLLECT;
            end
            if (term) begin
              upc_valid    <= hit;
              upc_error    <= !hit;
              if (hit) upc_out <= hit_code;
              state        <= DONE;
              letter_ready <= 1'b0;
            end
          end
        end
        DONE: begin
          state        <= IDLE;
          pos          <= '0;
          mask         <= '1;
          letter_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
